chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that accepts two WIDTH-bit operands and forms the sum CHUNK bits per clock. The carry is rippled between cycles through a carry register. It generalises the team's single-cycle 4-bit "+" adder to arbitrary width, adds a subtract mode and a signed-overflow flag, and adds a valid/ready handshake on both sides. It sits on datapaths where a full-width carry chain would not close timing and where throughput of one operation per WIDTH/CHUNK cycles is acceptable.

---
 rtl/adder_pkg.sv | 23 ++
 rtl/chunk_add_slice.sv | 24 ++
 rtl/chunk_adder.sv | 148 ++++++++++++++
 tb/tb_chunk_adder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked adder family.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  function automatic int unsigned calc_nchunk(input int unsigned width,
                                              input int unsigned chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int unsigned calc_idx_w(input int unsigned nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/chunk_add_slice.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its MSB
// so the caller can derive signed overflow on the last chunk.
module chunk_add_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             msb_ci
);

  logic [CHUNK:0] total;

  always_comb begin
    total  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    s      = total[CHUNK-1:0];
    co     = total[CHUNK];
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
    msb_ci = a[CHUNK-1] ^ b[CHUNK-1] ^ total[CHUNK-1];
  end

endmodule

// File: rtl/chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice reused each cycle with the
// carry held in a register between chunks; valid/ready on both sides.
module chunk_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IDX_W  = calc_idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  generate
    if ((WIDTH < 2) || (CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
      $error("chunk_adder: WIDTH must be >= 2 and an exact multiple of CHUNK");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH:0]     sum_q, sum_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK-1:0]   s_chunk;
  logic               co_chunk;
  logic               msb_ci_chunk;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_add_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a      (a_chunk),
    .b      (b_chunk),
    .ci     (carry_q),
    .s      (s_chunk),
    .co     (co_chunk),
    .msb_ci (msb_ci_chunk)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtract is folded into the operands: B is stored inverted and the
          // carry seeded with 1, so RUN never needs to know the mode.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*CHUNK +: CHUNK] = s_chunk;
          end
        end
        carry_d = co_chunk;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          sum_d[WIDTH] = co_chunk;
          ovf_d        = msb_ci_chunk ^ co_chunk;
          idx_d        = '0;
          state_d      = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    sum       = sum_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_chunk_adder.sv
// Self-checking bench for chunk_adder: four parameterisations checked every
// cycle against a transaction-level arithmetic model, plus literal vectors.
module tb_chunk_adder;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        in_valid [NI];
  logic        out_ready[NI];
  logic        cin      [NI];
  logic        sub      [NI];
  logic [15:0] a16      [NI];
  logic [15:0] b16      [NI];

  logic        ir0, ir1, ir2, ir3;
  logic        ov0, ov1, ov2, ov3;
  logic        of0, of1, of2, of3;
  logic [16:0] s0, s1, s2;
  logic [8:0]  s3;

  logic        ir_a[NI];
  logic        ov_a[NI];
  logic        of_a[NI];
  logic [16:0] s_a [NI];

  int n_chk  = 0;
  int n_fail = 0;

  bit          pending[NI];
  int          rdy    [NI];
  logic [16:0] m_sum  [NI];
  logic        m_ovf  [NI];
  int          cyc = 0;

  always #5 clk = ~clk;

  chunk_adder #(.WIDTH(16), .CHUNK(4)) u_w16_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir0),
    .a(a16[0]), .b(b16[0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(ov0), .out_ready(out_ready[0]), .sum(s0), .ovf(of0));

  chunk_adder #(.WIDTH(16), .CHUNK(1)) u_w16_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir1),
    .a(a16[1]), .b(b16[1]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(ov1), .out_ready(out_ready[1]), .sum(s1), .ovf(of1));

  chunk_adder #(.WIDTH(16), .CHUNK(16)) u_w16_c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(ir2),
    .a(a16[2]), .b(b16[2]), .cin(cin[2]), .sub(sub[2]),
    .out_valid(ov2), .out_ready(out_ready[2]), .sum(s2), .ovf(of2));

  chunk_adder #(.WIDTH(8), .CHUNK(2)) u_w8_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(ir3),
    .a(a16[3][7:0]), .b(b16[3][7:0]), .cin(cin[3]), .sub(sub[3]),
    .out_valid(ov3), .out_ready(out_ready[3]), .sum(s3), .ovf(of3));

  always_comb begin
    ir_a[0] = ir0; ir_a[1] = ir1; ir_a[2] = ir2; ir_a[3] = ir3;
    ov_a[0] = ov0; ov_a[1] = ov1; ov_a[2] = ov2; ov_a[3] = ov3;
    of_a[0] = of0; of_a[1] = of1; of_a[2] = of2; of_a[3] = of3;
    s_a[0]  = s0;  s_a[1]  = s1;  s_a[2]  = s2;  s_a[3]  = {8'h00, s3};
  end

  function automatic int w_of(input int k);
    return (k == 3) ? 8 : 16;
  endfunction

  function automatic int nc_of(input int k);
    case (k)
      0:       return 4;
      1:       return 16;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  // Reference: plain integer arithmetic. Result {ovf, carry/no-borrow, value}.
  function automatic logic [17:0] ref_op(input int w, input logic [15:0] av,
                                         input logic [15:0] bv, input logic ci,
                                         input logic sb);
    longint mask, half, ua, ub, sa, sbv, tot, sr;
    logic [16:0] s;
    logic o;
    mask = (64'd1 << w) - 1;
    half = 64'd1 << (w - 1);
    ua   = longint'(av) & mask;
    ub   = longint'(bv) & mask;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sbv  = (ub >= half) ? ub - 2 * half : ub;
    if (sb) begin
      tot = ((ua - ub) & mask) | ((ua >= ub) ? (64'd1 << w) : 64'd0);
      sr  = sa - sbv;
    end else begin
      tot = ua + ub + longint'(ci);
      sr  = sa + sbv + longint'(ci);
    end
    s = tot[16:0];
    o = (sr >= half) || (sr < -half);
    return {o, s};
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 9))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      4:       return 16'h0080;
      5:       return 16'h007F;
      default: return 16'($urandom);
    endcase
  endfunction

  // Transaction model: accept when idle, result due nc cycles later, retired
  // on the handshake edge.
  always @(posedge clk or posedge rst) begin
    logic [17:0] r;
    bit mv;
    if (rst) begin
      for (int k = 0; k < NI; k++) pending[k] = 1'b0;
    end else begin
      for (int k = 0; k < NI; k++) begin
        mv = pending[k] && (cyc >= rdy[k]);
        if (mv && out_ready[k]) begin
          pending[k] = 1'b0;
        end else if (!pending[k] && in_valid[k]) begin
          pending[k] = 1'b1;
          rdy[k]     = cyc + 1 + nc_of(k);
          r          = ref_op(w_of(k), a16[k], b16[k], cin[k], sub[k]);
          m_sum[k]   = r[16:0];
          m_ovf[k]   = r[17];
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        ev = pending[k] && (cyc >= rdy[k]);
        chk($sformatf("in_ready[%0d]", k), 32'(ir_a[k]), 32'(!pending[k]));
        chk($sformatf("out_valid[%0d]", k), 32'(ov_a[k]), 32'(ev));
        if (ev) begin
          chk($sformatf("sum[%0d]", k), 32'(s_a[k]), 32'(m_sum[k]));
          chk($sformatf("ovf[%0d]", k), 32'(of_a[k]), 32'(m_ovf[k]));
        end
      end
    end
  end

  task automatic issue(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic sb);
    @(posedge clk); #1;
    a16[k] = av; b16[k] = bv; cin[k] = ci; sub[k] = sb; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    a16[k] = 16'($urandom); b16[k] = 16'($urandom);
    cin[k] = 1'($urandom);  sub[k] = 1'($urandom);
  endtask

  // Called just after the accept edge; waits for the result, holds it for
  // `hold` cycles of backpressure, then completes the handshake.
  task automatic collect(input int k, input int hold, input logic [16:0] es,
                         input logic eo, input string name);
    bit got;
    int lat;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk); got = ov_a[k];
    end
    chk({name, "_out_valid_seen"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'(nc_of(k)));
    chk({name, "_sum"}, 32'(s_a[k]), 32'(es));
    chk({name, "_ovf"}, 32'(of_a[k]), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid[k] = 1'b1; a16[k] = 16'($urandom); b16[k] = 16'($urandom);
      @(negedge clk);
      chk({name, "_hold_sum"}, 32'(s_a[k]), 32'(es));
      chk({name, "_hold_ovf"}, 32'(of_a[k]), 32'(eo));
      chk({name, "_hold_in_ready"}, 32'(ir_a[k]), 32'd0);
      chk({name, "_hold_out_valid"}, 32'(ov_a[k]), 32'd1);
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    @(negedge clk);
    chk({name, "_idle_after_handshake"}, 32'(ir_a[k]), 32'd1);
  endtask

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [16:0] es;
    logic        eo;
  } vec_t;

  localparam int NV = 12;
  vec_t dv[NV];

  initial begin
    logic [17:0] r;
    dv = '{
      '{0, 16'h000F, 16'h0001, 1'b0, 1'b0, 17'h00010, 1'b0},
      '{0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0},
      '{0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1},
      '{0, 16'h0005, 16'h0003, 1'b1, 1'b1, 17'h10002, 1'b0},
      '{0, 16'h0003, 16'h0005, 1'b0, 1'b1, 17'h0FFFE, 1'b0},
      '{0, 16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1},
      '{0, 16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556, 1'b0},
      '{1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0},
      '{2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1},
      '{3, 16'h007F, 16'h0001, 1'b0, 1'b0, 17'h00080, 1'b1},
      '{3, 16'h0080, 16'h0001, 1'b0, 1'b1, 17'h0017F, 1'b1},
      '{2, 16'h0000, 16'h0001, 1'b0, 1'b1, 17'h0FFFF, 1'b0}
    };

    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      a16[k] = '0; b16[k] = '0; cin[k] = 1'b0; sub[k] = 1'b0;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset_in_ready[%0d]", k), 32'(ir_a[k]), 32'd1);
      chk($sformatf("reset_out_valid[%0d]", k), 32'(ov_a[k]), 32'd0);
      chk($sformatf("reset_sum[%0d]", k), 32'(s_a[k]), 32'd0);
      chk($sformatf("reset_ovf[%0d]", k), 32'(of_a[k]), 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      r = ref_op(w_of(dv[i].k), dv[i].a, dv[i].b, dv[i].ci, dv[i].sb);
      chk($sformatf("model_pin[%0d]", i), 32'(r), 32'({dv[i].eo, dv[i].es}));
      issue(dv[i].k, dv[i].a, dv[i].b, dv[i].ci, dv[i].sb);
      collect(dv[i].k, (i == 5) ? 5 : 0, dv[i].es, dv[i].eo, $sformatf("dir%0d", i));
    end

    // Reset during the second RUN cycle, then accept on the first edge after release.
    issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrun_rst_out_valid", 32'(ov_a[0]), 32'd0);
    chk("midrun_rst_sum", 32'(s_a[0]), 32'd0);
    chk("midrun_rst_ovf", 32'(of_a[0]), 32'd0);
    chk("midrun_rst_in_ready", 32'(ir_a[0]), 32'd1);
    @(negedge clk);
    a16[0] = 16'h1234; b16[0] = 16'h4321; cin[0] = 1'b0; sub[0] = 1'b0;
    in_valid[0] = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    collect(0, 0, 17'h05555, 1'b0, "post_rst");

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        out_ready[k] = ($urandom_range(0, 3) != 0);
        a16[k] = pick();
        b16[k] = pick();
        cin[k] = 1'($urandom);
        sub[k] = 1'($urandom);
      end
    end

    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
    repeat (25) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
